cp0_exc_seq: RTL and testbench

Exception/ERET sequencer and access arbiter in front of the CP0 register file. All CP0 writes share one data bus, so the block serializes exception entry (EPC, BadVAddr, Cause, Status) and ERET (Status) into single-register write cycles. It arbitrates those against pipeline MTC0/MFC0 accesses and issues the PC redirect to fetch. It sits between the pipeline's exception/MEM stage and the CP0 register file.

---
 rtl/cp0_exc_seq_pkg.sv | 38 +++
 rtl/cp0_exc_seq.sv | 187 ++++++++++++++++++
 tb/tb_cp0_exc_seq.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cp0_exc_seq_pkg.sv
// Shared CP0 definitions: register numbers, field positions, sequencer states
// and the data-formatting helpers used by the exception/ERET sequencer.
package cp0_exc_seq_pkg;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  localparam int STATUS_EXL_BIT = 1;
  localparam int CAUSE_BD_BIT   = 31;
  localparam int CAUSE_CODE_LSB = 2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_W_EPC    = 3'd1,
    ST_W_BADVA  = 3'd2,
    ST_W_CAUSE  = 3'd3,
    ST_W_STATUS = 3'd4,
    ST_E_STATUS = 3'd5,
    ST_REDIRECT = 3'd6
  } seq_state_e;

  // A delay-slot fault restarts at the branch, one word back.
  function automatic logic [31:0] epc_value(input logic [31:0] pc, input logic bd);
    return bd ? (pc - 32'd4) : pc;
  endfunction

  function automatic logic [31:0] cause_value(input logic [31:0] cause, input logic bd,
                                              input logic [4:0] code);
    logic [31:0] c;
    c = cause;
    c[CAUSE_BD_BIT] = bd;
    c[CAUSE_CODE_LSB +: 5] = code;
    return c;
  endfunction

endpackage

// File: rtl/cp0_exc_seq.sv
// Exception/ERET sequencer: serializes entry and return into single CP0
// register writes, arbitrates against pipeline MTC0/MFC0, issues the redirect.
module cp0_exc_seq
  import cp0_exc_seq_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0180,
  parameter int          EXL_BIT    = STATUS_EXL_BIT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_req,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        exc_bd,
  input  logic [31:0] exc_badva,
  input  logic        exc_badva_valid,
  input  logic        eret_req,
  output logic        exc_ack,
  output logic        eret_ack,
  input  logic        cpu_we,
  input  logic        cpu_re,
  input  logic [4:0]  cpu_rd,
  input  logic [2:0]  cpu_sel,
  input  logic [31:0] cpu_din,
  output logic [31:0] cpu_dout,
  output logic        cpu_rvalid,
  output logic        busy,
  output logic        cp0_we,
  output logic        cp0_re,
  output logic [4:0]  cp0_rd,
  output logic [2:0]  cp0_sel,
  output logic [31:0] cp0_din,
  input  logic [31:0] cp0_dout,
  input  logic [31:0] cp0_status,
  input  logic [31:0] cp0_cause,
  input  logic [31:0] cp0_epc,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  localparam logic [31:0] EXL_MASK = 32'd1 << EXL_BIT;

  seq_state_e  state_r, state_s;
  logic        busy_r;
  logic        rvalid_r;
  logic [4:0]  code_r;
  logic [31:0] pc_r;
  logic        bd_r;
  logic [31:0] badva_r;
  logic        badva_valid_r;
  logic [31:0] target_r;
  logic        exc_take_s;
  logic        eret_take_s;
  logic        cpu_pass_s;

  assign exc_take_s  = (state_r == ST_IDLE) && exc_req;
  assign eret_take_s = (state_r == ST_IDLE) && !exc_req && eret_req;
  assign cpu_pass_s  = (state_r == ST_IDLE) && !exc_req && !eret_req;

  assign busy       = busy_r;
  assign cpu_rvalid = rvalid_r;
  assign cpu_dout   = rvalid_r ? cp0_dout : 32'd0;

  // State, busy and MFC0 return-valid registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      busy_r   <= 1'b0;
      rvalid_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      busy_r   <= (state_s != ST_IDLE);
      rvalid_r <= cpu_pass_s && cpu_re;
    end
  end

  // Request latch bank, captured only at acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_r        <= 5'd0;
      pc_r          <= 32'd0;
      bd_r          <= 1'b0;
      badva_r       <= 32'd0;
      badva_valid_r <= 1'b0;
      target_r      <= 32'd0;
    end else if (exc_take_s) begin
      code_r        <= exc_code;
      pc_r          <= exc_pc;
      bd_r          <= exc_bd;
      badva_r       <= exc_badva;
      badva_valid_r <= exc_badva_valid;
      target_r      <= EXC_VECTOR;
    end else if (eret_take_s) begin
      target_r      <= cp0_epc;
    end
  end

  // Next-state logic; EPC is skipped for nested exceptions, BadVAddr when not supplied.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (exc_take_s) begin
          if (!cp0_status[EXL_BIT]) state_s = ST_W_EPC;
          else if (exc_badva_valid)  state_s = ST_W_BADVA;
          else                       state_s = ST_W_CAUSE;
        end else if (eret_take_s) begin
          state_s = ST_E_STATUS;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_W_EPC:    state_s = badva_valid_r ? ST_W_BADVA : ST_W_CAUSE;
      ST_W_BADVA:  state_s = ST_W_CAUSE;
      ST_W_CAUSE:  state_s = ST_W_STATUS;
      ST_W_STATUS: state_s = ST_REDIRECT;
      ST_E_STATUS: state_s = ST_REDIRECT;
      ST_REDIRECT: state_s = ST_IDLE;
      default:     state_s = ST_IDLE;
    endcase
  end

  // Output decode: sequencer writes, acks, redirect and idle pass-through.
  always_comb begin
    exc_ack        = 1'b0;
    eret_ack       = 1'b0;
    cp0_we         = 1'b0;
    cp0_re         = 1'b0;
    cp0_rd         = 5'd0;
    cp0_sel        = 3'd0;
    cp0_din        = 32'd0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    case (state_r)
      ST_IDLE: begin
        if (rst) begin
          exc_ack = 1'b0;
        end else begin
          exc_ack  = exc_take_s;
          eret_ack = eret_take_s;
          if (cpu_pass_s) begin
            cp0_we  = cpu_we;
            cp0_re  = cpu_re;
            cp0_rd  = cpu_rd;
            cp0_sel = cpu_sel;
            cp0_din = cpu_din;
          end else begin
            cp0_we = 1'b0;
          end
        end
      end
      ST_W_EPC: begin
        cp0_we  = 1'b1;
        cp0_rd  = CP0_EPC;
        cp0_din = epc_value(pc_r, bd_r);
      end
      ST_W_BADVA: begin
        cp0_we  = 1'b1;
        cp0_rd  = CP0_BADVADDR;
        cp0_din = badva_r;
      end
      ST_W_CAUSE: begin
        cp0_we  = 1'b1;
        cp0_rd  = CP0_CAUSE;
        cp0_din = cause_value(cp0_cause, bd_r, code_r);
      end
      ST_W_STATUS: begin
        cp0_we  = 1'b1;
        cp0_rd  = CP0_STATUS;
        cp0_din = cp0_status | EXL_MASK;
      end
      ST_E_STATUS: begin
        cp0_we  = 1'b1;
        cp0_rd  = CP0_STATUS;
        cp0_din = cp0_status & ~EXL_MASK;
      end
      ST_REDIRECT: begin
        redirect_valid = 1'b1;
        redirect_pc    = target_r;
      end
      default: begin
        cp0_we = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_cp0_exc_seq.sv
// Bench for cp0_exc_seq: table-driven MTC0/MFC0 pass-through plus a
// cycle-stamped scoreboard of expected CP0 writes and fetch redirects.
module tb_cp0_exc_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        exc_req, exc_bd, exc_badva_valid, eret_req;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc, exc_badva;
  logic        exc_ack, eret_ack;
  logic        cpu_we, cpu_re;
  logic [4:0]  cpu_rd;
  logic [2:0]  cpu_sel;
  logic [31:0] cpu_din, cpu_dout;
  logic        cpu_rvalid, busy;
  logic        cp0_we, cp0_re;
  logic [4:0]  cp0_rd;
  logic [2:0]  cp0_sel;
  logic [31:0] cp0_din, cp0_dout, cp0_status, cp0_cause, cp0_epc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  cp0_exc_seq dut (
    .clk(clk), .rst(rst),
    .exc_req(exc_req), .exc_code(exc_code), .exc_pc(exc_pc), .exc_bd(exc_bd),
    .exc_badva(exc_badva), .exc_badva_valid(exc_badva_valid),
    .eret_req(eret_req), .exc_ack(exc_ack), .eret_ack(eret_ack),
    .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_rd(cpu_rd), .cpu_sel(cpu_sel),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_rvalid(cpu_rvalid), .busy(busy),
    .cp0_we(cp0_we), .cp0_re(cp0_re), .cp0_rd(cp0_rd), .cp0_sel(cp0_sel),
    .cp0_din(cp0_din), .cp0_dout(cp0_dout), .cp0_status(cp0_status),
    .cp0_cause(cp0_cause), .cp0_epc(cp0_epc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {int cyc; logic [4:0] rd; logic [2:0] sel; logic [31:0] din;} wr_t;
  typedef struct {int cyc; logic [31:0] pc;} rdr_t;
  typedef struct {
    logic we; logic re; logic [4:0] rd; logic [2:0] sel; logic [31:0] din;
    logic [31:0] rf; logic exp_rvalid; logic [31:0] exp_dout;
  } vec_t;

  wr_t  wq[$];
  rdr_t rq[$];
  vec_t vecs[6];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   t0 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_wr(input int c, input logic [4:0] rd, input logic [31:0] din);
    wr_t e;
    e.cyc = c; e.rd = rd; e.sel = 3'd0; e.din = din;
    wq.push_back(e);
  endtask

  task automatic exp_rdr(input int c, input logic [31:0] pc);
    rdr_t e;
    e.cyc = c; e.pc = pc;
    rq.push_back(e);
  endtask

  // Sample on the falling edge against the scoreboards, then advance one cycle.
  task automatic step();
    wr_t  w;
    rdr_t r;
    @(negedge clk);
    if (cp0_we) begin
      if (wq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_write: got rd=%0d din=%h want no write (cycle %0d)", cp0_rd, cp0_din, cyc);
      end else begin
        w = wq.pop_front();
        chk("wr_cycle", cyc, w.cyc);
        chk("wr_rd", {27'd0, cp0_rd}, {27'd0, w.rd});
        chk("wr_sel", {29'd0, cp0_sel}, {29'd0, w.sel});
        chk("wr_din", cp0_din, w.din);
      end
    end
    if (redirect_valid) begin
      if (rq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_redirect: got pc=%h want none (cycle %0d)", redirect_pc, cyc);
      end else begin
        r = rq.pop_front();
        chk("redir_cycle", cyc, r.cyc);
        chk("redir_pc", redirect_pc, r.pc);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic start_exc(input logic [4:0] code, input logic [31:0] pc, input logic bd,
                           input logic [31:0] badva, input logic bv);
    exc_code = code; exc_pc = pc; exc_bd = bd; exc_badva = badva; exc_badva_valid = bv;
    exc_req = 1'b1;
    #1;
    chk("exc_ack", {31'd0, exc_ack}, 32'd1);
    chk("eret_ack_excl", {31'd0, eret_ack}, 32'd0);
    t0 = cyc;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 12 && busy; i++) step();
    chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic drain_check(input string name);
    chk({name, "_wq_empty"}, wq.size(), 32'd0);
    chk({name, "_rq_empty"}, rq.size(), 32'd0);
    wq.delete();
    rq.delete();
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 5'd12, 3'd0, 32'h0000_0001, 32'h0,         1'b0, 32'h0};
    vecs[1] = '{1'b0, 1'b1, 5'd13, 3'd0, 32'h0,         32'h0000_0010, 1'b1, 32'h0000_0010};
    vecs[2] = '{1'b1, 1'b0, 5'd9,  3'd0, 32'hFFFF_FFFF, 32'h1111_1111, 1'b0, 32'h0};
    vecs[3] = '{1'b0, 1'b1, 5'd15, 3'd1, 32'h0,         32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF};
    vecs[4] = '{1'b0, 1'b0, 5'd3,  3'd2, 32'h0,         32'h2222_2222, 1'b0, 32'h0};
    vecs[5] = '{1'b0, 1'b1, 5'd16, 3'd7, 32'h0,         32'h0,         1'b1, 32'h0};

    // Reset with every request asserted: all outputs must stay low.
    rst = 1'b1;
    exc_req = 1'b1; eret_req = 1'b1; exc_code = 5'd3; exc_pc = 32'h0040_0000;
    exc_bd = 1'b1; exc_badva = 32'h0; exc_badva_valid = 1'b1;
    cpu_we = 1'b1; cpu_re = 1'b1; cpu_rd = 5'd12; cpu_sel = 3'd1; cpu_din = 32'hFFFF_FFFF;
    cp0_dout = 32'hA5A5_A5A5; cp0_status = 32'h0; cp0_cause = 32'h0; cp0_epc = 32'h0;
    step();
    step();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_exc_ack", {31'd0, exc_ack}, 32'd0);
    chk("rst_eret_ack", {31'd0, eret_ack}, 32'd0);
    chk("rst_cp0_we", {31'd0, cp0_we}, 32'd0);
    chk("rst_cp0_re", {31'd0, cp0_re}, 32'd0);
    chk("rst_redir_valid", {31'd0, redirect_valid}, 32'd0);
    chk("rst_redir_pc", redirect_pc, 32'd0);
    chk("rst_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    chk("rst_dout", cpu_dout, 32'd0);
    exc_req = 1'b0; eret_req = 1'b0; cpu_we = 1'b0; cpu_re = 1'b0;
    step();
    rst = 1'b0;
    step();

    // Table-driven MTC0/MFC0 pass-through in IDLE.
    for (int i = 0; i < 6; i++) begin
      cpu_we = vecs[i].we; cpu_re = vecs[i].re; cpu_rd = vecs[i].rd;
      cpu_sel = vecs[i].sel; cpu_din = vecs[i].din;
      #1;
      chk("pass_we", {31'd0, cp0_we}, {31'd0, vecs[i].we});
      chk("pass_re", {31'd0, cp0_re}, {31'd0, vecs[i].re});
      if (vecs[i].we) exp_wr(cyc, vecs[i].rd, vecs[i].din);
      if (vecs[i].we) wq[wq.size()-1].sel = vecs[i].sel;
      step();
      cpu_we = 1'b0; cpu_re = 1'b0;
      cp0_dout = vecs[i].rf;
      #1;
      chk("mfc0_rvalid", {31'd0, cpu_rvalid}, {31'd0, vecs[i].exp_rvalid});
      chk("mfc0_dout", cpu_dout, vecs[i].exp_dout);
      step();
    end
    drain_check("table");

    // Full exception entry.
    cp0_status = 32'h0; cp0_cause = 32'h0000_0300;
    start_exc(5'd4, 32'h0040_0010, 1'b0, 32'h1234_5678, 1'b1);
    exp_wr(t0 + 1, 5'd14, 32'h0040_0010);
    exp_wr(t0 + 2, 5'd8,  32'h1234_5678);
    exp_wr(t0 + 3, 5'd13, 32'h0000_0310);
    exp_wr(t0 + 4, 5'd12, 32'h0000_0002);
    exp_rdr(t0 + 5, 32'h8000_0180);
    step();
    exc_req = 1'b0;
    chk("busy_rise", {31'd0, busy}, 32'd1);
    wait_idle();
    chk("full_idle_cycle", cyc, t0 + 6);
    drain_check("full");

    // Delay-slot exception, no BadVAddr.
    start_exc(5'd5, 32'h0040_0020, 1'b1, 32'hFFFF_FFFF, 1'b0);
    exp_wr(t0 + 1, 5'd14, 32'h0040_001C);
    exp_wr(t0 + 2, 5'd13, 32'h8000_0314);
    exp_wr(t0 + 3, 5'd12, 32'h0000_0002);
    exp_rdr(t0 + 4, 32'h8000_0180);
    step();
    exc_req = 1'b0;
    wait_idle();
    drain_check("bd");

    // Nested exception: EXL already set, old BD bit must be replaced.
    cp0_status = 32'h0000_0002; cp0_cause = 32'h8000_0300;
    start_exc(5'd12, 32'h0040_0030, 1'b0, 32'h0, 1'b0);
    exp_wr(t0 + 1, 5'd13, 32'h0000_0330);
    exp_wr(t0 + 2, 5'd12, 32'h0000_0002);
    exp_rdr(t0 + 3, 32'h8000_0180);
    step();
    exc_req = 1'b0;
    wait_idle();
    drain_check("nested");

    // ERET.
    cp0_status = 32'h0000_0003; cp0_epc = 32'h0040_0100;
    eret_req = 1'b1;
    #1;
    chk("eret_ack", {31'd0, eret_ack}, 32'd1);
    chk("eret_no_exc_ack", {31'd0, exc_ack}, 32'd0);
    t0 = cyc;
    exp_wr(t0 + 1, 5'd12, 32'h0000_0001);
    exp_rdr(t0 + 2, 32'h0040_0100);
    step();
    eret_req = 1'b0;
    wait_idle();
    drain_check("eret");

    // exc + eret + MTC0 together: exception wins, others held and retried.
    cp0_status = 32'h0; cp0_cause = 32'h0; cp0_epc = 32'h0;
    eret_req = 1'b1;
    cpu_we = 1'b1; cpu_rd = 5'd9; cpu_sel = 3'd0; cpu_din = 32'h5555_AAAA;
    start_exc(5'd8, 32'h0040_0040, 1'b0, 32'h0, 1'b0);
    chk("coll_cpu_blocked", {31'd0, cp0_we}, 32'd0);
    exp_wr(t0 + 1, 5'd14, 32'h0040_0040);
    exp_wr(t0 + 2, 5'd13, 32'h0000_0020);
    exp_wr(t0 + 3, 5'd12, 32'h0000_0002);
    exp_rdr(t0 + 4, 32'h8000_0180);
    step();
    exc_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("coll_eret_held", {31'd0, eret_ack}, 32'd0);
      step();
    end
    cp0_status = 32'h0000_0002; cp0_epc = 32'h0040_0044;
    step();
    chk("coll_eret_ack", {31'd0, eret_ack}, 32'd1);
    chk("coll_eret_cycle", cyc, t0 + 5);
    exp_wr(t0 + 6, 5'd12, 32'h0000_0000);
    exp_rdr(t0 + 7, 32'h0040_0044);
    step();
    eret_req = 1'b0;
    wait_idle();
    chk("coll_mtc0_pass", {31'd0, cp0_we}, 32'd1);
    exp_wr(cyc, 5'd9, 32'h5555_AAAA);
    step();
    cpu_we = 1'b0;
    drain_check("collide");

    // Reset two cycles into an exception: nothing after EPC, then clean restart.
    cp0_status = 32'h0; cp0_cause = 32'h0;
    start_exc(5'd1, 32'h0040_0080, 1'b0, 32'h0000_0ABC, 1'b1);
    exp_wr(t0 + 1, 5'd14, 32'h0040_0080);
    step();
    exc_req = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_we", {31'd0, cp0_we}, 32'd0);
    chk("mid_rst_redir", {31'd0, redirect_valid}, 32'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step();
    drain_check("midrst");
    start_exc(5'd2, 32'h0040_0090, 1'b0, 32'h0000_0DEF, 1'b1);
    exp_wr(t0 + 1, 5'd14, 32'h0040_0090);
    exp_wr(t0 + 2, 5'd8,  32'h0000_0DEF);
    exp_wr(t0 + 3, 5'd13, 32'h0000_0008);
    exp_wr(t0 + 4, 5'd12, 32'h0000_0002);
    exp_rdr(t0 + 5, 32'h8000_0180);
    step();
    exc_req = 1'b0;
    wait_idle();
    drain_check("restart");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
